timer_tick_scheduler: RTL

Sequencer that owns the interval timer's 16-bit memory-mapped slave port. It programs the timer's period, starts it in continuous interrupt mode, and services each timeout by clearing the status register. It fans each timer tick out to NUM_SLOTS independent software-style down-counters, each raising a one-cycle expire pulse. It sits between the timer peripheral and the OS-tick, watchdog and scheduler consumers.

---
 rtl/timer_sched_pkg.sv | 28 ++
 rtl/timer_tick_scheduler_slot.sv | 41 ++++
 rtl/timer_tick_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: sequencer states, timer register map and control words
package timer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_CLR,
        ST_TICK,
        ST_WR_STOP
    } state_t;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    localparam logic [15:0] CTRL_RUN  = 16'((1 << ITO) | (1 << CONT) | (1 << START));
    localparam logic [15:0] CTRL_STOP = 16'(1 << STOP);

endpackage

// File: rtl/timer_tick_scheduler_slot.sv
// tick_slot: one reloadable down-counter that pulses o_expire when it wraps
module tick_slot #(
    parameter int SLOT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_tick,
    input  logic              i_cfg_we,
    input  logic [SLOT_W-1:0] i_cfg_reload,
    output logic              o_expire
);

    logic [SLOT_W-1:0] r_reload;
    logic [SLOT_W-1:0] r_count;
    logic              r_expire;

    assign o_expire = r_expire;

    // Configuration beats a simultaneous tick; a zero reload keeps the slot silent
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (i_cfg_we) begin
                r_reload <= i_cfg_reload;
                r_count  <= i_cfg_reload;
            end else if (i_tick && r_reload != '0) begin
                if (r_count == SLOT_W'(1)) begin
                    r_expire <= 1'b1;
                    r_count  <= r_reload;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler: programs the interval timer, services its timeouts and fans ticks out to slots
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int          NUM_SLOTS   = 4,
    parameter int          SLOT_W      = 16,
    parameter logic [31:0] TICK_PERIOD = 32'd49999
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic                                                   i_start,
    input  logic                                                   i_stop,
    input  logic                                                   i_cfg_we,
    input  logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0]   i_cfg_slot,
    input  logic [SLOT_W-1:0]                                      i_cfg_reload,
    output logic [2:0]                                             o_tmr_address,
    output logic                                                   o_tmr_chipselect,
    output logic                                                   o_tmr_write_n,
    output logic [15:0]                                            o_tmr_writedata,
    input  logic                                                   i_tmr_irq,
    output logic [NUM_SLOTS-1:0]                                   o_expire,
    output logic                                                   o_running,
    output logic                                                   o_busy,
    output logic [31:0]                                            o_tick_count
);

    localparam int CW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t      r_state;
    logic        r_stop_pend;
    logic        r_running;
    logic        r_busy;
    logic        r_cs;
    logic        r_wn;
    logic [2:0]  r_addr;
    logic [15:0] r_wd;
    logic [31:0] r_tick_count;
    logic        w_tick;

    assign o_tmr_address    = r_addr;
    assign o_tmr_chipselect = r_cs;
    assign o_tmr_write_n    = r_wn;
    assign o_tmr_writedata  = r_wd;
    assign o_running        = r_running;
    assign o_busy           = r_busy;
    assign o_tick_count     = r_tick_count;

    // Slots advance on the edge that enters TICK, together with the tick counter
    assign w_tick = (r_state == ST_CLR);

    // Sequencer: one registered bus write per state, run/stop control and tick accounting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_stop_pend  <= 1'b0;
            r_running    <= 1'b0;
            r_busy       <= 1'b0;
            r_cs         <= 1'b0;
            r_wn         <= 1'b1;
            r_addr       <= '0;
            r_wd         <= '0;
            r_tick_count <= '0;
        end else begin
            r_cs   <= 1'b0;
            r_wn   <= 1'b1;
            r_addr <= '0;
            r_wd   <= '0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state      <= ST_WR_PL;
                    r_busy       <= 1'b1;
                    r_tick_count <= '0;
                    r_stop_pend  <= 1'b0;
                    r_cs         <= 1'b1;
                    r_wn         <= 1'b0;
                    r_addr       <= TMR_PERIODL;
                    r_wd         <= TICK_PERIOD[15:0];
                end
                ST_WR_PL: begin
                    r_state     <= ST_WR_PH;
                    r_stop_pend <= r_stop_pend | i_stop;
                    r_cs        <= 1'b1;
                    r_wn        <= 1'b0;
                    r_addr      <= TMR_PERIODH;
                    r_wd        <= TICK_PERIOD[31:16];
                end
                ST_WR_PH: begin
                    r_state     <= ST_WR_CTRL;
                    r_stop_pend <= r_stop_pend | i_stop;
                    r_cs        <= 1'b1;
                    r_wn        <= 1'b0;
                    r_addr      <= TMR_CONTROL;
                    r_wd        <= CTRL_RUN;
                end
                ST_WR_CTRL: begin
                    r_state     <= ST_RUN;
                    r_stop_pend <= r_stop_pend | i_stop;
                    r_running   <= 1'b1;
                    r_busy      <= 1'b0;
                end
                ST_RUN: if (r_stop_pend || i_stop) begin
                    r_state     <= ST_WR_STOP;
                    r_stop_pend <= 1'b0;
                    r_busy      <= 1'b1;
                    r_cs        <= 1'b1;
                    r_wn        <= 1'b0;
                    r_addr      <= TMR_CONTROL;
                    r_wd        <= CTRL_STOP;
                end else if (i_tmr_irq) begin
                    r_state <= ST_CLR;
                    r_busy  <= 1'b1;
                    r_cs    <= 1'b1;
                    r_wn    <= 1'b0;
                    r_addr  <= TMR_STATUS;
                end
                ST_CLR: begin
                    r_state      <= ST_TICK;
                    r_stop_pend  <= r_stop_pend | i_stop;
                    r_tick_count <= r_tick_count + 1'b1;
                end
                ST_TICK: begin
                    r_state     <= ST_RUN;
                    r_stop_pend <= r_stop_pend | i_stop;
                    r_busy      <= 1'b0;
                end
                ST_WR_STOP: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        tick_slot #(.SLOT_W(SLOT_W)) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_tick       (w_tick),
            .i_cfg_we     (i_cfg_we && i_cfg_slot == CW'(g)),
            .i_cfg_reload (i_cfg_reload),
            .o_expire     (o_expire[g])
        );
    end

endmodule
